// File: rtl/alu_control_if.sv
// alu_control_if: decode request (ALUOp/FuncCode) and registered ALU select response
interface alu_control_if #(
   parameter int CTL_W  = 4,
   parameter int FUNC_W = 6
) ();
   logic              in_valid;
   logic [1:0]        ALUOp;
   logic [FUNC_W-1:0] FuncCode;
   logic [CTL_W-1:0]  ALUctl;
   logic              out_valid;
   logic              illegal;
   modport master (output in_valid, ALUOp, FuncCode, input ALUctl, out_valid, illegal);
   modport slave  (input in_valid, ALUOp, FuncCode, output ALUctl, out_valid, illegal);
endinterface

// File: rtl/alu_control.sv
// alu_control: decodes ALUOp and R-type funct into a registered 4-bit ALU select
module alu_control #(
   parameter int                 CTL_W    = 4,
   parameter int                 FUNC_W   = 6,
   parameter logic [CTL_W-1:0]   ILL_CODE = 4'b1111
) (
   input  logic          clk,
   input  logic          reset,
   alu_control_if.slave  bus
);
   logic [CTL_W-1:0]  fn_ctl, dec_ctl, ctl_d, ctl_q;
   logic [FUNC_W-1:0] fn;
   logic              fn_ill, ill_d, ill_q, vld_q;
   assign fn = bus.FuncCode;
   always_comb begin
      fn_ctl = ILL_CODE;
      fn_ill = 1'b1;
      case (fn)
         6'b100000, 6'b100001: begin fn_ctl = CTL_W'(4'b0010); fn_ill = 1'b0; end
         6'b100010, 6'b100011: begin fn_ctl = CTL_W'(4'b0110); fn_ill = 1'b0; end
         6'b100100:            begin fn_ctl = CTL_W'(4'b0000); fn_ill = 1'b0; end
         6'b100101:            begin fn_ctl = CTL_W'(4'b0001); fn_ill = 1'b0; end
         6'b100111:            begin fn_ctl = CTL_W'(4'b1100); fn_ill = 1'b0; end
         6'b101010:            begin fn_ctl = CTL_W'(4'b0111); fn_ill = 1'b0; end
         default: ;
      endcase
   end
   assign dec_ctl = bus.ALUOp == 2'b10 ? fn_ctl :
                    bus.ALUOp == 2'b01 ? CTL_W'(4'b0110) :
                    bus.ALUOp == 2'b11 ? CTL_W'(4'b0001) : CTL_W'(4'b0010);
   // Idle cycles keep the last select and illegal flag so the ALU input stays stable
   assign ctl_d = bus.in_valid ? dec_ctl : ctl_q;
   assign ill_d = bus.in_valid ? (bus.ALUOp == 2'b10 && fn_ill) : ill_q;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ctl_q <= '0;
         ill_q <= 1'b0;
         vld_q <= 1'b0;
      end else begin
         ctl_q <= ctl_d;
         ill_q <= ill_d;
         vld_q <= bus.in_valid;
      end
   end
   assign bus.ALUctl    = ctl_q;
   assign bus.illegal   = ill_q;
   assign bus.out_valid = vld_q;
endmodule

// File: tb/tb_alu_control.sv
// tb_alu_control: directed vectors with hand-computed ALU selects
module tb_alu_control;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int failures = 0;
   alu_control_if bus ();
   alu_control dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask
   task automatic outs(input string tag, input logic [3:0] ctl, input logic ill, input logic vld);
      check({tag, ".ctl"}, {4'b0, bus.ALUctl}, {4'b0, ctl});
      check({tag, ".ill"}, {7'b0, bus.illegal}, {7'b0, ill});
      check({tag, ".vld"}, {7'b0, bus.out_valid}, {7'b0, vld});
   endtask
   task automatic apply(input string tag, input logic v, input logic [1:0] op, input logic [5:0] fn,
                        input logic [3:0] ctl, input logic ill, input logic vld);
      @(negedge clk);
      bus.in_valid = v;
      bus.ALUOp    = op;
      bus.FuncCode = fn;
      @(posedge clk);
      #1;
      outs(tag, ctl, ill, vld);
   endtask
   initial begin
      bus.in_valid = 1'b0;
      bus.ALUOp    = 2'b00;
      bus.FuncCode = 6'b0;
      repeat (3) @(posedge clk);
      #1;
      outs("rst", 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      // load/store: funct ignored
      apply("ls0", 1, 2'b00, 6'b000000, 4'b0010, 0, 1);
      apply("ls1", 1, 2'b00, 6'b100000, 4'b0010, 0, 1);
      apply("ls2", 1, 2'b00, 6'b100010, 4'b0010, 0, 1);
      apply("ls3", 1, 2'b00, 6'b100100, 4'b0010, 0, 1);
      apply("ls4", 1, 2'b00, 6'b100101, 4'b0010, 0, 1);
      apply("ls5", 1, 2'b00, 6'b101010, 4'b0010, 0, 1);
      // R-type
      apply("add",  1, 2'b10, 6'b100000, 4'b0010, 0, 1);
      apply("sub",  1, 2'b10, 6'b100010, 4'b0110, 0, 1);
      apply("and",  1, 2'b10, 6'b100100, 4'b0000, 0, 1);
      apply("or",   1, 2'b10, 6'b100101, 4'b0001, 0, 1);
      apply("slt",  1, 2'b10, 6'b101010, 4'b0111, 0, 1);
      apply("nor",  1, 2'b10, 6'b100111, 4'b1100, 0, 1);
      apply("addu", 1, 2'b10, 6'b100001, 4'b0010, 0, 1);
      apply("subu", 1, 2'b10, 6'b100011, 4'b0110, 0, 1);
      apply("br",   1, 2'b01, 6'b101010, 4'b0110, 0, 1);
      apply("ori",  1, 2'b11, 6'b101010, 4'b0001, 0, 1);
      // illegal funct codes, including ones differing only in bits [5:4]
      apply("ill0", 1, 2'b10, 6'b000000, 4'b1111, 1, 1);
      apply("radd", 1, 2'b10, 6'b100000, 4'b0010, 0, 1);
      apply("ill1", 1, 2'b10, 6'b000010, 4'b1111, 1, 1);
      apply("ill2", 1, 2'b10, 6'b110000, 4'b1111, 1, 1);
      apply("ill3", 1, 2'b10, 6'b100110, 4'b1111, 1, 1);
      apply("hil",  0, 2'b00, 6'b100000, 4'b1111, 1, 0);
      apply("oklw", 1, 2'b00, 6'b000000, 4'b0010, 0, 1);
      // hold after SUB
      apply("hsub", 1, 2'b10, 6'b100010, 4'b0110, 0, 1);
      apply("h1",   0, 2'b00, 6'b100100, 4'b0110, 0, 0);
      apply("h2",   0, 2'b11, 6'b000000, 4'b0110, 0, 0);
      apply("h3",   0, 2'b10, 6'b000000, 4'b0110, 0, 0);
      // async reset between edges
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      outs("arst", 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      apply("post0", 0, 2'b10, 6'b100111, 4'b0000, 0, 0);
      apply("post1", 1, 2'b10, 6'b100111, 4'b1100, 0, 1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
